dec_mux_add_arbiter: RTL and testbench

Round-robin scheduler that shares one decoder/mux/adder datapath among four requesters. It selects one pending operand pair per transaction, drives it through the shared adder, and returns the registered sum tagged with the requester ID. It sits in front of the DecMuxAdd datapath so multiple producers never drive it concurrently.

---
 rtl/dec_mux_add_arbiter.sv | 147 ++++++++++++++
 tb/tb_dec_mux_add_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_mux_add_arbiter.sv
// dec_mux_add_arbiter
//
// Round-robin front end for a shared decoder/mux/adder datapath. Four
// requesters present operand pairs; one is granted per transaction, its
// operands are captured, added in the next cycle, and the registered sum is
// returned with the requester index until the consumer accepts it.
//
// Handshake semantics (both sides): a transfer happens on the rising edge
// where valid & ready are both high. req_valid is level-sensitive and may be
// dropped at any time before it is granted; req_ready is a one-hot grant that
// only ever appears in IDLE. rsp_valid/rsp_sum/rsp_id stay stable while
// rsp_valid is high and rsp_ready is low.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   req_valid  [3:0]          per-requester request pending
//   req_a      [4*WIDTH-1:0]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      [4*WIDTH-1:0]  operand B, same packing
//   req_ready  [3:0]          one-hot grant (combinational)
//   rsp_valid                 result available
//   rsp_ready                 consumer accepts result
//   rsp_sum    [WIDTH:0]      A+B with carry in the MSB
//   rsp_id     [1:0]          requester that owns rsp_sum
//   busy                      high whenever not in IDLE
//   state_dbg  [1:0]          current FSM state (0 IDLE, 1 EXEC, 2 RESP)

module dec_mux_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  output logic [3:0]         req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH:0]     rsp_sum,
  output logic [1:0]         rsp_id,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       ptr;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       id_q;

  logic             grant;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Round-robin search starting at ptr. Walking the offsets from farthest to
  // nearest lets the nearest pending requester overwrite the others.
  always_comb begin
    grant = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req_valid[idx]) begin
        grant = 1'b1;
        win   = idx;
      end
    end
  end

  // Operand mux: pick the winner's slice of the packed operand buses.
  always_comb begin
    sel_a = req_a[WIDTH-1:0];
    sel_b = req_b[WIDTH-1:0];
    for (int i = 0; i < 4; i++) begin
      if (win == 2'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grant is suppressed during reset so nothing is handed out on an edge
  // that will not capture it.
  always_comb begin
    req_ready = 4'b0000;
    if (state == IDLE && grant && !rst) begin
      req_ready = 4'b0001 << win;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      op_a      <= '0;
      op_b      <= '0;
      id_q      <= 2'd0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= 2'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant) begin
            op_a <= sel_a;
            op_b <= sel_b;
            id_q <= win;
            ptr  <= win + 2'd1;
          end
        end
        EXEC: begin
          rsp_sum   <= {1'b0, op_a} + {1'b0, op_b};
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_dec_mux_add_arbiter.sv
// Bench for dec_mux_add_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all watched by a transaction-level model.

module tb_dec_mux_add_arbiter;

  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic [3:0]     req_valid = 4'b0000;
  logic [4*W-1:0] req_a = '0;
  logic [4*W-1:0] req_b = '0;
  logic [3:0]     req_ready;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [W:0]     rsp_sum;
  logic [1:0]     rsp_id;
  logic           busy;
  logic [1:0]     state_dbg;

  dec_mux_add_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: a granted transaction waits one cycle in exp_q ({id,sum}), then
  // becomes the visible response held until accepted.
  logic [10:0] exp_q[$];
  logic [1:0]  m_ptr = 2'd0;
  bit          m_out_valid = 1'b0;
  logic [8:0]  m_out_sum = '0;
  logic [1:0]  m_out_id = '0;

  always @(negedge clk) begin
    int w;
    int s;
    bit e_busy;
    logic [3:0] e_ready;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      s = (int'(m_ptr) + k) % 4;
      if (w < 0 && req_valid[s]) w = s;
    end
    e_busy  = (exp_q.size() != 0) || m_out_valid;
    e_ready = (!rst && !e_busy && w >= 0) ? 4'(1 << w) : 4'b0000;
    check("m_req_ready", 32'(req_ready), 32'(e_ready));
    check("m_busy", 32'(busy), 32'(e_busy));
    check("m_rsp_valid", 32'(rsp_valid), 32'(m_out_valid));
    if (m_out_valid) begin
      check("m_rsp_sum", 32'(rsp_sum), 32'(m_out_sum));
      check("m_rsp_id", 32'(rsp_id), 32'(m_out_id));
    end
    if (rst) begin
      exp_q.delete();
      m_out_valid = 1'b0;
      m_ptr = 2'd0;
    end else if (m_out_valid) begin
      if (rsp_ready) m_out_valid = 1'b0;
    end else if (exp_q.size() != 0) begin
      {m_out_id, m_out_sum} = exp_q.pop_front();
      m_out_valid = 1'b1;
    end else if (w >= 0) begin
      exp_q.push_back({2'(w), 9'(req_a[w*W +: W]) + 9'(req_b[w*W +: W])});
      m_ptr = 2'((w + 1) % 4);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (req_ready != 4'b0000) begin
        g = req_ready;
        return;
      end
      step();
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (rsp_valid) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    bit ok;
    int gq[$];
    int gc[$];
    int sq[$];
    logic [W:0] held_sum;
    logic [1:0] held_id;

    // reset state, with requests pending to show the grant is held off
    req_valid = 4'b1111;
    sample();
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_sum", 32'(rsp_sum), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    step();

    // single request
    do_reset();
    req_valid = 4'b0100;
    set_ops(2, 8'h7F, 8'h01);
    sample();
    check("single_grant", 32'(req_ready), 32'h4);
    check("single_busy0", 32'(busy), 0);
    step();
    req_valid = 4'b0000;
    sample();
    check("single_busy1", 32'(busy), 1);
    check("single_valid1", 32'(rsp_valid), 0);
    step();
    sample();
    check("single_valid2", 32'(rsp_valid), 1);
    check("single_sum", 32'(rsp_sum), 32'h080);
    check("single_id", 32'(rsp_id), 2);
    check("single_busy2", 32'(busy), 1);
    step();
    sample();
    check("single_busy3", 32'(busy), 0);
    step();

    // carry out of the top bit
    do_reset();
    req_valid = 4'b0001;
    set_ops(0, 8'hFF, 8'hFF);
    wait_grant(g);
    check("carry_grant", 32'(g), 32'h1);
    step();
    req_valid = 4'b0000;
    wait_rsp(ok);
    check("carry_rsp_seen", 32'(ok), 1);
    check("carry_sum", 32'(rsp_sum), 32'h1FE);
    check("carry_id", 32'(rsp_id), 0);
    step();

    // round-robin fairness
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 8'(i), 8'h10);
    req_valid = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      sample();
      if (req_ready != 4'b0000) begin
        gq.push_back(oh_idx(req_ready));
        gc.push_back(c);
      end
      if (rsp_valid) sq.push_back(int'(rsp_sum));
      step();
    end
    check("rr_grant_count", 32'(gq.size()), 5);
    check("rr_rsp_count", 32'(sq.size()), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < gq.size()) begin
        check("rr_order", 32'(gq[i]), 32'(i % 4));
        check("rr_spacing", 32'(gc[i]), 32'(3 * i));
      end
      if (i < sq.size()) check("rr_sum", 32'(sq[i]), 32'(32'h10 + (i % 4)));
    end
    req_valid = 4'b0000;

    // backpressure: five cycles held in RESP with other requests pending
    do_reset();
    req_valid = 4'b0001;
    set_ops(0, 8'h33, 8'h44);
    rsp_ready = 1'b0;
    wait_grant(g);
    check("bp_grant", 32'(g), 32'h1);
    step();
    req_valid = 4'b1111;
    wait_rsp(ok);
    check("bp_rsp_seen", 32'(ok), 1);
    check("bp_sum", 32'(rsp_sum), 32'h077);
    held_sum = rsp_sum;
    held_id  = rsp_id;
    for (int i = 0; i < 5; i++) begin
      check("bp_stable_valid", 32'(rsp_valid), 1);
      check("bp_stable_sum", 32'(rsp_sum), 32'(held_sum));
      check("bp_stable_id", 32'(rsp_id), 32'(held_id));
      check("bp_no_grant", 32'(req_ready), 0);
      step();
      sample();
    end
    rsp_ready = 1'b1;
    step();
    sample();
    check("bp_idle_busy", 32'(busy), 0);
    check("bp_next_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) step();

    // pointer wrap: after granting 1, only 0 and 3 request
    do_reset();
    req_valid = 4'b0010;
    set_ops(1, 8'h05, 8'h06);
    set_ops(0, 8'h01, 8'h02);
    set_ops(3, 8'hA0, 8'h0B);
    wait_grant(g);
    check("wrap_grant1", 32'(g), 32'h2);
    step();
    req_valid = 4'b1001;
    wait_grant(g);
    check("wrap_grant3", 32'(g), 32'h8);
    step();
    wait_grant(g);
    check("wrap_grant0", 32'(g), 32'h1);
    step();
    req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) step();

    // reset while in EXEC with every requester pending
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 8'(8'h80 + i), 8'h70);
    req_valid = 4'b1111;
    wait_grant(g);
    check("rexec_first", 32'(g), 32'h1);
    step();
    wait_grant(g);
    check("rexec_second", 32'(g), 32'h2);
    step();
    rst = 1'b1;
    sample();
    check("rexec_in_exec", 32'(busy), 1);
    step();
    rst = 1'b0;
    sample();
    check("rexec_valid_low", 32'(rsp_valid), 0);
    check("rexec_busy_low", 32'(busy), 0);
    check("rexec_regrant0", 32'(req_ready), 32'h1);
    step();
    sample();
    check("rexec_no_rsp", 32'(rsp_valid), 0);
    step();
    sample();
    check("rexec_rsp_valid", 32'(rsp_valid), 1);
    check("rexec_rsp_id", 32'(rsp_id), 0);
    check("rexec_rsp_sum", 32'(rsp_sum), 32'h0F0);
    step();

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 600; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) set_ops(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b0;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    sample();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
